instruction_memory_responder: RTL
=================================

// Module: instruction_memory_responder
// PURPOSE
//  Memory-side responder for the instruction fetch path. Holds a 2^ADDR_SIZE x WORD_SIZE
//  program store and serves fetch requests addressed by program_counter, returning the word
//  on memory_data_register. The data path runs into instruction_fetch.
//  Also provides a write port that the control unit / loader uses to fill or patch the store.
//  Fetch wait states are programmable to model slow program memory.
// PARAMETERS
//  WORD_SIZE    16  instruction/data word width
//  ADDR_SIZE    8   address width; depth = 2**ADDR_SIZE (256)
//  WAIT_STATES  1   extra cycles between request accept and response; legal 0..7
// PORTS
//  clk                    in   1          rising-edge clock; all state updates on posedge clk
//  rst                    in   1          synchronous, active-high reset
//  fetch_req              in   1          fetch request; held until accepted
//  program_counter        in   ADDR_SIZE  fetch address; sampled on accept
//  fetch_ready            out  1          responder can accept a fetch this cycle
//  memory_data_register   out  WORD_SIZE  fetched word; holds until next response
//  fetch_valid            out  1          1-cycle pulse: memory_data_register carries new word
//  wr_en                  in   1          write request; held until wr_ack
//  wr_addr                in   ADDR_SIZE  write address
//  wr_data                in   WORD_SIZE  write data
//  wr_ack                 out  1          1-cycle pulse, cycle after write committed
//  busy                   out  1          state != S_IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=S_IDLE, wait counter=0, memory_data_register=0,
//   fetch_valid=0, wr_ack=0, latched address=0. Storage array NOT cleared.
//  Reset mid-operation: aborts pending fetch; no fetch_valid is produced for it.
//  FSM states: S_IDLE, S_WAIT, S_RESP.
//   S_IDLE: fetch_ready = !wr_en (combinational). Write has priority over fetch.
//    wr_en=1 -> mem[wr_addr]<=wr_data, wr_ack=1 next cycle, stay S_IDLE.
//    else fetch_req=1 -> latch program_counter; WAIT_STATES==0 ? S_RESP : S_WAIT (cnt=0).
//   S_WAIT: fetch_ready=0; cnt increments; at cnt==WAIT_STATES-1 -> S_RESP.
//   S_RESP: memory_data_register<=mem[latched addr], fetch_valid=1 next cycle; -> S_IDLE.
//  Latency: accept edge to fetch_valid high = WAIT_STATES+2 cycles (WAIT_STATES=1 -> 3).
//  Back-to-back: new fetch accepted the cycle fetch_valid is high (state back in S_IDLE);
//   no bubble besides the FSM path.
//  wr_en while busy: ignored until S_IDLE; no wr_ack until committed; writes never dropped.
//  Read-after-write: fetch accepted after wr_ack returns the newly written word.
//  fetch_req and wr_en same cycle in S_IDLE: write commits, fetch waits (fetch_ready=0).
//  Addresses use full ADDR_SIZE range; 0 and 2**ADDR_SIZE-1 both valid; no wrap logic here
//   (PC increment wraps upstream at 8 bits).
//  fetch_valid and wr_ack are never high for >1 consecutive cycle per transaction.
// TESTING
//  T1 reset: drive rst=1 2 cycles mid-fetch -> all outputs 0, busy=0, no fetch_valid after.
//  T2 write+read: write 16'hA5C3 @8'h10 -> wr_ack pulse; fetch @8'h10 (WAIT_STATES=1)
//   -> fetch_valid 3 cycles after accept, memory_data_register=16'hA5C3.
//  T3 boundary addr: write 16'h0001 @8'h00, 16'hFFFF @8'hFF; fetch both -> exact values.
//  T4 collision: wr_en and fetch_req same cycle in S_IDLE, wr 16'h1234 @8'h20, fetch @8'h20
//   -> fetch_ready=0, write first, fetch then returns 16'h1234.
//  T5 write during busy: wr_en raised in S_WAIT -> no wr_ack until S_IDLE, data committed once.
//  T6 WAIT_STATES=0 and 7: fetch_valid at accept+2 and accept+9 cycles; back-to-back stream
//   of 4 fetches @0..3 returns words in order.

Source files
------------

// File: rtl/instruction_memory_responder.sv
// Program-store responder for the instruction fetch path: serves fetches with
// programmable wait states, and accepts loader writes that take priority when idle.
module instruction_memory_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int ADDR_SIZE   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [ADDR_SIZE-1:0] program_counter,
    output logic                 fetch_ready,
    output logic [WORD_SIZE-1:0] memory_data_register,
    output logic                 fetch_valid,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 wr_ack,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_SIZE;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] LAST_WAIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic [1:0]           state_reg, state_next;
    logic [2:0]           cnt_reg, cnt_next;
    logic [ADDR_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0] rd_data_reg;
    logic [WORD_SIZE-1:0] mdr_reg;
    logic                 rd_pending_reg;
    logic                 fetch_valid_reg;
    logic                 wr_ack_reg;

    logic do_write;
    logic do_accept;

    // A write present in S_IDLE always wins; the fetch simply stays pending.
    assign do_write  = (state_reg == S_IDLE) && wr_en;
    assign do_accept = (state_reg == S_IDLE) && !wr_en && fetch_req;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (do_accept) begin
                    cnt_next   = 3'd0;
                    state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg == LAST_WAIT) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Storage has no reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_addr] <= wr_data;
        end
        if (state_reg == S_RESP) begin
            rd_data_reg <= mem[addr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= 3'd0;
            addr_reg        <= '0;
            rd_pending_reg  <= 1'b0;
            mdr_reg         <= '0;
            fetch_valid_reg <= 1'b0;
            wr_ack_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            rd_pending_reg  <= (state_reg == S_RESP);
            fetch_valid_reg <= rd_pending_reg;
            wr_ack_reg      <= do_write;
            if (do_accept) begin
                addr_reg <= program_counter;
            end
            // RAM output lands one cycle after S_RESP, then is published with fetch_valid.
            if (rd_pending_reg) begin
                mdr_reg <= rd_data_reg;
            end
        end
    end

    assign fetch_ready          = (state_reg == S_IDLE) && !wr_en;
    assign memory_data_register = mdr_reg;
    assign fetch_valid          = fetch_valid_reg;
    assign wr_ack               = wr_ack_reg;
    assign busy                 = (state_reg != S_IDLE);

endmodule
